// File: rtl/jtcontra_gfx_romarb.sv
// Two-port arbiter sharing one graphics ROM (SDRAM) slot between the tile and object
// fetchers. Holds each request until the ROM reply is valid, then returns the data to that port.
module jtcontra_gfx_romarb #(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int SETTLE = 2,
  parameter int PRIO   = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_cs,
  input  logic [AW-1:0] a_addr,
  output logic          a_ok,
  output logic [DW-1:0] a_data,
  input  logic          b_cs,
  input  logic [AW-1:0] b_addr,
  output logic          b_ok,
  output logic [DW-1:0] b_data,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok
);

  typedef enum logic [1:0] {IDLE, WAIT, BUSY} state_t;

  state_t        state, state_nx;
  logic          gnt_b, gnt_b_nx;
  logic          last_b, last_b_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] a_lat, a_lat_nx, b_lat, b_lat_nx;
  logic [AW-1:0] rom_addr_nx;
  logic          rom_cs_nx, a_ok_nx, b_ok_nx;
  logic [DW-1:0] a_data_nx, b_data_nx;

  logic          a_pend, b_pend, pick_b, abort;
  logic          g_cs;
  logic [AW-1:0] g_addr, g_lat;

  // A port whose ok is already up for the same address has nothing left to ask for
  assign a_pend = a_cs & ~(a_ok & (a_addr == a_lat));
  assign b_pend = b_cs & ~(b_ok & (b_addr == b_lat));
  assign pick_b = b_pend & (~a_pend | ((PRIO == 0) & ~last_b));

  assign g_cs   = gnt_b ? b_cs   : a_cs;
  assign g_addr = gnt_b ? b_addr : a_addr;
  assign g_lat  = gnt_b ? b_lat  : a_lat;
  assign abort  = ~g_cs | (g_addr != g_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_b    <= 1'b0;
      last_b   <= 1'b1;
      cnt      <= 4'd0;
      a_lat    <= '0;
      b_lat    <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      a_ok     <= 1'b0;
      b_ok     <= 1'b0;
      a_data   <= '0;
      b_data   <= '0;
    end else begin
      state    <= state_nx;
      gnt_b    <= gnt_b_nx;
      last_b   <= last_b_nx;
      cnt      <= cnt_nx;
      a_lat    <= a_lat_nx;
      b_lat    <= b_lat_nx;
      rom_cs   <= rom_cs_nx;
      rom_addr <= rom_addr_nx;
      a_ok     <= a_ok_nx;
      b_ok     <= b_ok_nx;
      a_data   <= a_data_nx;
      b_data   <= b_data_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    gnt_b_nx    = gnt_b;
    last_b_nx   = last_b;
    cnt_nx      = cnt;
    a_lat_nx    = a_lat;
    b_lat_nx    = b_lat;
    rom_cs_nx   = rom_cs;
    rom_addr_nx = rom_addr;
    a_ok_nx     = a_ok & a_cs & (a_addr == a_lat);
    b_ok_nx     = b_ok & b_cs & (b_addr == b_lat);
    a_data_nx   = a_data;
    b_data_nx   = b_data;

    case (state)
      IDLE: begin
        rom_cs_nx = 1'b0;
        if (a_pend | b_pend) begin
          gnt_b_nx  = pick_b;
          rom_cs_nx = 1'b1;
          cnt_nx    = 4'(SETTLE);
          state_nx  = WAIT;
          if (pick_b) begin
            rom_addr_nx = b_addr;
            b_lat_nx    = b_addr;
          end else begin
            rom_addr_nx = a_addr;
            a_lat_nx    = a_addr;
          end
        end
      end
      // rom_ok may still describe the previous address here, so it is not looked at
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (abort) begin
          rom_cs_nx = 1'b0;
          state_nx  = IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          rom_cs_nx = 1'b0;
          state_nx  = IDLE;
        end else if (rom_ok) begin
          rom_cs_nx = 1'b0;
          last_b_nx = gnt_b;
          state_nx  = IDLE;
          if (gnt_b) begin
            b_data_nx = rom_data;
            b_ok_nx   = 1'b1;
          end else begin
            a_data_nx = rom_data;
            a_ok_nx   = 1'b1;
          end
        end
      end
      default: begin
        rom_cs_nx = 1'b0;
        state_nx  = IDLE;
      end
    endcase
  end

endmodule
